mem_stage: RTL

- MEM stage of the 5-stage MIPS pipeline. It sits between the EX/MEM stage register and the WB stage.
- Resolves branches: PCSrc and branch target go to IF.
- Drives a data-memory bus with a req/ready handshake, holding the upstream pipeline while an access is outstanding.
- Contains the MEM/WB stage register feeding write-back.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/memwb_reg.sv | 30 +++
 rtl/mem_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared MEM-stage types: FSM states, widths, MEM/WB vector.
// Revision : 1.0
// ============================================================================
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem2reg;
    logic [DATA_W-1:0]     read_data;
    logic [DATA_W-1:0]     alu;
    logic [REG_ADDR_W-1:0] write_reg;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/memwb_reg.sv
`default_nettype none
// ============================================================================
// Module   : memwb_reg
// Brief    : MEM/WB pipeline register; a bubble request loads the zero vector.
// Revision : 1.0
// ============================================================================
module memwb_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_bubble,
  input  memwb_t i_d,
  output memwb_t o_q
);

  memwb_t r_q;

  always_ff @(posedge clk) begin
    if (rst || i_bubble) begin
      r_q <= MEMWB_BUBBLE;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : MIPS MEM stage: branch resolve, data-bus handshake with timeout,
//            alignment check and MEM/WB register.
// Revision : 1.0
// ============================================================================
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Branch_in,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  input  logic                  RegWrite_in,
  input  logic                  Mem2Reg_in,
  input  logic                  Zero_in,
  input  logic [DATA_W-1:0]     PC_in,
  input  logic [DATA_W-1:0]     ALU_in,
  input  logic [DATA_W-1:0]     Reg2_in,
  input  logic [REG_ADDR_W-1:0] WriteReg_in,
  input  logic                  MemReady_in,
  input  logic [DATA_W-1:0]     MemRData_in,
  output logic                  MemReq_out,
  output logic                  MemWe_out,
  output logic [DATA_W-1:0]     MemAddr_out,
  output logic [DATA_W-1:0]     MemWData_out,
  output logic                  Stall_out,
  output logic                  PCSrc_out,
  output logic [DATA_W-1:0]     BranchTarget_out,
  output logic                  RegWrite_out,
  output logic                  Mem2Reg_out,
  output logic [DATA_W-1:0]     ReadData_out,
  output logic [DATA_W-1:0]     ALU_out,
  output logic [REG_ADDR_W-1:0] WriteReg_out,
  output logic                  AlignErr_out,
  output logic                  BusErr_out
);

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_align_err, r_bus_err;
  logic             w_align_nxt, w_bus_nxt;
  logic             w_stall, w_bubble, w_take_rdata;
  logic             w_op, w_mis;
  memwb_t           w_memwb_d, w_memwb_q;

  assign w_op  = MemRead_in | MemWrite_in;
  assign w_mis = w_op & (ALU_in[1:0] != 2'b00);

  assign MemReq_out       = w_op & ~w_mis & ~rst;
  assign MemWe_out        = MemWrite_in;
  assign MemAddr_out      = ALU_in;
  assign MemWData_out     = Reg2_in;
  assign PCSrc_out        = Branch_in & Zero_in;
  assign BranchTarget_out = PC_in;
  assign Stall_out        = w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_align_err <= w_align_nxt;
      r_bus_err   <= w_bus_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stall      = 1'b0;
    w_bubble     = 1'b1;
    w_take_rdata = 1'b0;
    w_align_nxt  = 1'b0;
    w_bus_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_op) begin
          w_bubble = 1'b0;
        end else if (w_mis) begin
          w_align_nxt = 1'b1;
        end else if (MemReady_in) begin
          w_bubble     = 1'b0;
          w_take_rdata = 1'b1;
        end else begin
          w_stall     = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion wins over a timeout landing in the same cycle.
        if (MemReady_in) begin
          w_bubble     = 1'b0;
          w_take_rdata = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_IDLE;
        end else if (r_cnt == c_timeout) begin
          w_bus_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_memwb_d = '{reg_write: RegWrite_in,
                       mem2reg:   Mem2Reg_in,
                       read_data: w_take_rdata ? MemRData_in : '0,
                       alu:       ALU_in,
                       write_reg: WriteReg_in};

  memwb_reg u_memwb_reg (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (w_bubble),
    .i_d      (w_memwb_d),
    .o_q      (w_memwb_q)
  );

  assign RegWrite_out = w_memwb_q.reg_write;
  assign Mem2Reg_out  = w_memwb_q.mem2reg;
  assign ReadData_out = w_memwb_q.read_data;
  assign ALU_out      = w_memwb_q.alu;
  assign WriteReg_out = w_memwb_q.write_reg;
  assign AlignErr_out = r_align_err;
  assign BusErr_out   = r_bus_err;

endmodule
`default_nettype wire
